// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the instruction/data memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Read data returned to the requester when an access is aborted.
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT      = 15;

  localparam int STREAK_W = 3;
  localparam int TMO_W    = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch port, data port, stall outputs and memory command bus.
// Latency: n/a (wiring only).
// Backpressure: stalls and req/ack flow through unchanged.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  // pipeline freeze
  logic              stall_if;
  logic              stall_mem;

  // backing memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  // Arbiter view: consumes requests and memory responses, drives everything else.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  // Environment view: pipeline stages plus backing memory.
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/arb_streak_counter.sv
// Purpose: saturating count of consecutive data grants taken while a fetch waits.
// Latency: count updates one cycle after inc/clr; at_limit is combinational from the count.
// Backpressure: none; inc is ignored once the limit is reached, clr wins over inc.
module arb_streak_counter
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  input  logic [STREAK_W-1:0] limit,
  output logic                at_limit
);

  logic [STREAK_W-1:0] count;

  // Count up on inc, hold at the limit, clear on request.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch and data ports with a data-streak starvation guard.
// Latency: mem_req one cycle after grant, valid one cycle after ack (or timeout), re-arbitrate the cycle after valid.
// Backpressure: requester held in stall until its valid pulse; memory holds us off via mem_ack, bounded by TIMEOUT.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);
  // Last BUSY cycle count before abort: counter starts at 0 in the first BUSY cycle.
  localparam logic [TMO_W-1:0]    TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0]   ERR_DATA     = DATA_W'(ARB_ERR_DATA);

  arb_state_t        state, state_nxt;
  cmd_t              cmd;
  logic              mem_req;
  logic [DATA_W-1:0] if_rdata, d_rdata;
  logic              if_valid, d_valid, err;
  logic [TMO_W-1:0]  tmo_cnt;

  logic busy, grant_d, grant_i, ack_take, tmo_hit, finish;
  logic streak_inc, streak_clr, streak_at_limit;

  arb_streak_counter u_streak (
    .clk      (clk),
    .reset    (reset),
    .inc      (streak_inc),
    .clr      (streak_clr),
    .limit    (STREAK_LIMIT),
    .at_limit (streak_at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack/timeout in BUSY, one response cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
        end else if (grant_i) begin
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: grants, completion, streak bookkeeping.
  always_comb begin
    busy       = (state == BUSY_I) || (state == BUSY_D);
    grant_d    = (state == IDLE) && bus.d_req && !(bus.if_req && streak_at_limit);
    grant_i    = (state == IDLE) && bus.if_req && !grant_d;
    ack_take   = busy && bus.mem_ack;
    tmo_hit    = busy && !bus.mem_ack && (tmo_cnt == TMO_LAST);
    finish     = ack_take || tmo_hit;
    streak_inc = grant_d && bus.if_req;
    streak_clr = grant_i || (grant_d && !bus.if_req);
  end

  // Timeout counter: restart on each grant, count every BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (grant_d || grant_i) begin
      tmo_cnt <= '0;
    end else if (busy && (tmo_cnt != '1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Memory command, response data and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req  <= 1'b0;
      cmd      <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      if (grant_d) begin
        mem_req <= 1'b1;
        cmd     <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
      end else if (grant_i) begin
        mem_req <= 1'b1;
        cmd     <= '{we: 1'b0, addr: bus.if_addr, wdata: '0};
      end
      if (finish) begin
        mem_req <= 1'b0;
        err     <= tmo_hit;
        if (state == BUSY_I) begin
          if_valid <= 1'b1;
          if_rdata <= tmo_hit ? ERR_DATA : bus.mem_rdata;
        end else begin
          d_valid <= 1'b1;
          // Writes return zero so the MEM stage never sees stale read data.
          d_rdata <= tmo_hit ? ERR_DATA : (cmd.we ? '0 : bus.mem_rdata);
        end
      end
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.if_rdata  = if_rdata;
  assign bus.if_valid  = if_valid;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_valid   = d_valid;
  assign bus.err       = err;
  // Stalls release in the valid cycle so the stage advances with the data.
  assign bus.stall_if  = bus.if_req & ~if_valid;
  assign bus.stall_mem = bus.d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each slot starts 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%b exp=000", bus.if_valid, bus.d_valid, bus.err); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.if_rdata, bus.d_rdata); end
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    checks++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1) begin
      errors++; $display("FAIL reset_stall_follow got=%b%b exp=11", bus.stall_if, bus.stall_mem); end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    #1;
    checks++; if (bus.stall_if !== 1'b0 || bus.stall_mem !== 1'b0) begin
      errors++; $display("FAIL reset_stall_low got=%b%b exp=00", bus.stall_if, bus.stall_mem); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    // cycle 0
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    checks++; if (bus.stall_if !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c0 stall/mem_req got=%b/%b exp=1/0", bus.stall_if, bus.mem_req); end
    tick(); // cycle 1
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_c1 cmd got=%b/%h/%b exp=1/40/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    checks++; if (bus.stall_if !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall got=%b exp=1", bus.stall_if); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8C220004;
    tick(); // cycle 2
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h8C220004) begin
      errors++; $display("FAIL fetch_c2 valid/rdata got=%b/%h exp=1/8c220004", bus.if_valid, bus.if_rdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b0 || bus.d_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_c2 mem_req/stall/d_valid got=%b/%b/%b exp=0/0/0", bus.mem_req, bus.stall_if, bus.d_valid); end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick(); // cycle 3
    checks++; if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c3 got valid=%b mem_req=%b exp=0/0", bus.if_valid, bus.mem_req); end
  endtask

  task automatic test_simultaneous();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h100;
    tick(); // cycle 1
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      errors++; $display("FAIL simul_c1 got=%b/%h exp=1/100", bus.mem_req, bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11112222;
    tick(); // cycle 2
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h11112222 || bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL simul_c2 got=%b/%h/%b exp=1/11112222/0", bus.d_valid, bus.d_rdata, bus.if_valid); end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick(); // cycle 3
    checks++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1) begin
      errors++; $display("FAIL simul_c3 got mem_req=%b stall_if=%b exp=0/1", bus.mem_req, bus.stall_if); end
    tick(); // cycle 4
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44) begin
      errors++; $display("FAIL simul_c4 got=%b/%h exp=1/44", bus.mem_req, bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h33334444;
    tick(); // cycle 5
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h33334444) begin
      errors++; $display("FAIL simul_c5 got=%b/%h exp=1/33334444", bus.if_valid, bus.if_rdata); end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick(); // idle
  endtask

  task automatic test_starvation();
    int exp_fetch [6] = '{0, 0, 0, 0, 1, 0};
    logic [31:0] daddr;
    daddr       = 32'h1000;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = daddr;
    for (int g = 0; g < 6; g++) begin
      tick(); // command cycle
      if (exp_fetch[g] == 1) begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
          errors++; $display("FAIL starve_grant%0d got=%b/%h exp=1/80 (fetch)", g, bus.mem_req, bus.mem_addr); end
      end else begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== daddr) begin
          errors++; $display("FAIL starve_grant%0d got=%b/%h exp=1/%h (data)", g, bus.mem_req, bus.mem_addr, daddr); end
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hA000_0000 + g;
      tick(); // valid cycle
      checks++; if ({bus.if_valid, bus.d_valid} !== ((exp_fetch[g] == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_valid%0d got if/d=%b%b", g, bus.if_valid, bus.d_valid); end
      bus.mem_ack = 1'b0;
      if (exp_fetch[g] == 0) begin
        daddr      = daddr + 32'h4;
        bus.d_addr = daddr;
      end
      tick(); // arbitration cycle
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h20;
    bus.d_wdata   = 32'h12345678;
    bus.mem_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin
        errors++; $display("FAIL write_c%0d got=%b/%b/%h/%h exp=1/1/20/12345678", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      checks++; if (bus.stall_mem !== 1'b1) begin errors++; $display("FAIL write_stall_c%0d got=%b exp=1", c, bus.stall_mem); end
    end
    bus.mem_ack = 1'b1;
    tick(); // cycle 4
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL write_resp got=%b/%h/%b exp=1/0/0", bus.d_valid, bus.d_rdata, bus.err); end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    for (int c = 1; c <= 15; c++) begin
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.d_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_hold_c%0d got req=%b valid=%b exp=1/0", c, bus.mem_req, bus.d_valid); end
    end
    tick(); // cycle 16
    checks++; if (bus.d_valid !== 1'b1 || bus.err !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_c16 got=%b/%b/%h/%b exp=1/1/deadbeef/0", bus.d_valid, bus.err, bus.d_rdata, bus.mem_req); end
    bus.d_req = 1'b0;
    tick(); // cycle 17: spurious ack
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55555555;
    checks++; if (bus.d_valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL timeout_c17 got=%b/%b exp=0/0", bus.d_valid, bus.err); end
    tick(); // cycle 18
    checks++; if (bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.err !== 1'b0 || bus.mem_req !== 1'b0 || bus.d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL spurious_ack got=%b/%b/%b/%b/%h", bus.d_valid, bus.if_valid, bus.err, bus.mem_req, bus.d_rdata); end
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    tick(); // cycle 1
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_c1 mem_req got=%b exp=1", bus.mem_req); end
    tick(); // cycle 2
    reset = 1'b1;
    tick(); // cycle 3
    checks++; if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_c3 got=%b/%b/%h exp=0/0/0", bus.mem_req, bus.if_valid, bus.if_rdata); end
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77777777;
    tick(); // cycle 4
    checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL rmid_late_ack got=%b/%b/%b exp=0/0/0", bus.if_valid, bus.d_valid, bus.mem_req); end
    bus.mem_ack = 1'b0;
    tick(); // cycle 5
    checks++; if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_c5 got=%b/%h exp=0/0", bus.if_valid, bus.if_rdata); end
    // A fresh request is granted immediately, proving the arbiter sits in IDLE.
    bus.if_req = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin
      errors++; $display("FAIL rmid_regrant got=%b/%h exp=1/300", bus.mem_req, bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL rmid_refetch got=%b/%h exp=1/0badf00d", bus.if_valid, bus.if_rdata); end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
